axi_burst_master: RTL and testbench

- AXI4 (full) master: the initiator side of the memory-mapped host interface the GPU already exposes as a slave.
- Lets GPU-side logic (DMA, framebuffer copy, register mirroring) issue single- or multi-beat INCR bursts to system memory on gpu_clk.
- Converts a simple command handshake plus write/read data streams into AW/W/B and AR/R channel traffic.
- One transaction is outstanding at a time.

---
 rtl/axi_burst_master_if.sv | 62 ++++++
 rtl/axi_burst_master.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 master-side channel bundle for axi_burst_master.
// The master modport drives AW/W/AR and the B/R ready signals; the slave modport is the mirror image.
interface axi_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: a command handshake plus write/read beat streams
// are turned into AW/W/B or AR/R traffic, finishing with a one-cycle done pulse and a merged response.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_ADDR | presenting the write address (registered awvalid)
// WR_DATA | write beats passed straight through to the W channel
// WR_RESP | waiting for the write response
// RD_ADDR | presenting the read address (registered arvalid)
// RD_DATA | read beats passed straight through from the R channel
// DONE    | one-cycle completion pulse, resp valid
module axi_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16
) (
  input  logic                    gpu_clk,
  input  logic                    reset,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [8:0]              cmd_len,

  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,

  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,

  output logic                    done,
  output logic [1:0]              resp,

  axi_burst_master_if.master      M_AXI
);

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [1:0]              resp_q;
  logic                    awvalid_q;
  logic                    arvalid_q;
  logic [8:0]              len_eff;
  logic [7:0]              len_m1;
  logic                    w_hs;
  logic                    r_hs;

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Zero means one beat; anything above MAX_LEN is clamped rather than split.
  always_comb begin
    len_eff = cmd_len;
    if (cmd_len == 9'd0) begin
      len_eff = 9'd1;
    end else if (cmd_len > MAX_LEN_W) begin
      len_eff = MAX_LEN_W;
    end
  end

  assign len_m1 = 8'(len_eff - 9'd1);

  assign w_hs = wr_valid && M_AXI.wready;
  assign r_hs = M_AXI.rvalid && rd_ready;

  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    M_AXI.wvalid = 1'b0;
    M_AXI.bready = 1'b0;
    M_AXI.rready = 1'b0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_n = cmd_write ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (M_AXI.awready) begin
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        M_AXI.wvalid = wr_valid;
        wr_ready     = M_AXI.wready;
        if (w_hs && (cnt_q == 8'd0)) begin
          state_n = WR_RESP;
        end
      end
      WR_RESP: begin
        M_AXI.bready = 1'b1;
        if (M_AXI.bvalid) begin
          state_n = DONE;
        end
      end
      RD_ADDR: begin
        if (M_AXI.arready) begin
          state_n = RD_DATA;
        end
      end
      RD_DATA: begin
        rd_valid     = M_AXI.rvalid;
        M_AXI.rready = rd_ready;
        rd_last      = M_AXI.rlast;
        if (r_hs && (M_AXI.rlast || (cnt_q == 8'd0))) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr & ~ADDR_WIDTH'(3);
            len_q     <= len_m1;
            cnt_q     <= len_m1;
            resp_q    <= 2'b00;
            awvalid_q <= cmd_write;
            arvalid_q <= !cmd_write;
          end
        end
        WR_ADDR: begin
          if (M_AXI.awready) begin
            awvalid_q <= 1'b0;
          end
        end
        WR_DATA: begin
          if (w_hs && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        WR_RESP: begin
          if (M_AXI.bvalid) begin
            resp_q <= worst(resp_q, M_AXI.bresp);
          end
        end
        RD_ADDR: begin
          if (M_AXI.arready) begin
            arvalid_q <= 1'b0;
          end
        end
        RD_DATA: begin
          // A burst that runs out of beats without rlast is closed anyway and flagged as a slave error.
          if (r_hs) begin
            if (M_AXI.rlast) begin
              resp_q <= worst(resp_q, M_AXI.rresp);
            end else if (cnt_q == 8'd0) begin
              resp_q <= RESP_SLVERR;
            end else begin
              resp_q <= worst(resp_q, M_AXI.rresp);
              cnt_q  <= cnt_q - 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign M_AXI.awaddr  = addr_q;
  assign M_AXI.awlen   = len_q;
  assign M_AXI.awsize  = 3'b010;
  assign M_AXI.awburst = 2'b01;
  assign M_AXI.awvalid = awvalid_q;

  assign M_AXI.wdata   = wr_data;
  assign M_AXI.wstrb   = wr_strb;
  assign M_AXI.wlast   = (cnt_q == 8'd0);

  assign M_AXI.araddr  = addr_q;
  assign M_AXI.arlen   = len_q;
  assign M_AXI.arsize  = 3'b010;
  assign M_AXI.arburst = 2'b01;
  assign M_AXI.arvalid = arvalid_q;

  assign rd_data = M_AXI.rdata;
  assign resp    = resp_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a bench-side slave and stream source, with a scoreboard
// of expected AW/AR fields, W beats, read beats and completion responses checked every cycle.
module tb_axi_burst_master;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXL = 16;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } wbeat_t;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rbeat_t;

  logic          gpu_clk   = 1'b0;
  logic          reset     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [8:0]    cmd_len   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic [3:0]    wr_strb   = '0;
  logic          wr_valid  = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_valid;
  logic          rd_ready  = 1'b1;
  logic          done;
  logic [1:0]    resp;

  axi_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

  axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LEN(MAXL)) dut (
    .gpu_clk   (gpu_clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .done      (done),
    .resp      (resp),
    .M_AXI     (m_axi)
  );

  always #5 gpu_clk = ~gpu_clk;

  int checks = 0;
  int passes = 0;

  wbeat_t src_w[$];
  wbeat_t exp_w[$];
  rbeat_t r_src[$];
  rbeat_t exp_rd[$];

  logic [31:0] exp_addr = '0;
  logic [7:0]  exp_len = '0;
  logic [1:0]  exp_resp = '0;
  logic        busy = 1'b0;
  int          done_cnt = 0;
  logic [7:0]  last_axlen = '0;
  logic [31:0] last_axaddr = '0;

  int          w_stall = 0;
  int          w_gap = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          r_stall = 1'b0;
  bit          rdr_toggle = 1'b0;

  logic s_w_hs = 1'b0, s_wlast_hs = 1'b0, s_b_hs = 1'b0, s_ar_hs = 1'b0, s_r_hs = 1'b0;
  logic          prev_wstall = 1'b0;
  logic [DW-1:0] prev_wdata = '0;
  logic [3:0]    prev_wstrb = '0;
  wbeat_t        wb;
  rbeat_t        rb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: sampled on the falling edge, away from the DUT's active edge.
  initial begin
    forever begin
      @(negedge gpu_clk);
      if (reset) begin
        s_w_hs = 0; s_wlast_hs = 0; s_b_hs = 0; s_ar_hs = 0; s_r_hs = 0;
        prev_wstall = 0;
      end else begin
        s_w_hs     = wr_valid & wr_ready;
        s_wlast_hs = m_axi.wvalid & m_axi.wready & m_axi.wlast;
        s_b_hs     = m_axi.bvalid & m_axi.bready;
        s_ar_hs    = m_axi.arvalid & m_axi.arready;
        s_r_hs     = m_axi.rvalid & m_axi.rready;

        chk("cmd_ready", 64'(cmd_ready), 64'(!busy));
        if (cmd_valid && cmd_ready) busy = 1'b1;

        if (m_axi.awvalid && m_axi.awready) begin
          chk("awaddr", 64'(m_axi.awaddr), 64'(exp_addr));
          chk("awlen", 64'(m_axi.awlen), 64'(exp_len));
          chk("awsize", 64'(m_axi.awsize), 64'(3'b010));
          chk("awburst", 64'(m_axi.awburst), 64'(2'b01));
          last_axlen  = m_axi.awlen;
          last_axaddr = m_axi.awaddr;
        end
        if (m_axi.arvalid && m_axi.arready) begin
          chk("araddr", 64'(m_axi.araddr), 64'(exp_addr));
          chk("arlen", 64'(m_axi.arlen), 64'(exp_len));
          chk("arsize", 64'(m_axi.arsize), 64'(3'b010));
          chk("arburst", 64'(m_axi.arburst), 64'(2'b01));
          last_axlen  = m_axi.arlen;
          last_axaddr = m_axi.araddr;
        end

        if (prev_wstall)
          chk("w_hold", 64'({m_axi.wvalid, m_axi.wstrb, m_axi.wdata}),
              64'({1'b1, prev_wstrb, prev_wdata}));
        prev_wstall = m_axi.wvalid & ~m_axi.wready;
        prev_wdata  = m_axi.wdata;
        prev_wstrb  = m_axi.wstrb;

        if (m_axi.wvalid && m_axi.wready) begin
          if (exp_w.size() == 0) chk("w_extra_beat", 64'(1), 64'(0));
          else begin
            wb = exp_w.pop_front();
            chk("wdata", 64'(m_axi.wdata), 64'(wb.d));
            chk("wstrb", 64'(m_axi.wstrb), 64'(wb.s));
            chk("wlast", 64'(m_axi.wlast), 64'(wb.l));
          end
        end

        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) chk("rd_extra_beat", 64'(1), 64'(0));
          else begin
            rb = exp_rd.pop_front();
            chk("rd_data", 64'(rd_data), 64'(rb.d));
            chk("rd_last", 64'(rd_last), 64'(rb.l));
          end
        end

        if (done) begin
          chk("resp_at_done", 64'(resp), 64'(exp_resp));
          chk("beats_left_at_done", 64'(exp_w.size() + exp_rd.size()), 64'(0));
          done_cnt++;
          busy = 1'b0;
        end
      end
    end
  end

  // Slave model and write-stream source, updated just after each rising edge.
  initial begin
    int gapcnt = 0;
    int wcnt = 0;
    int rcyc = 0;
    bit r_go = 0;
    m_axi.awready = 1'b1;
    m_axi.arready = 1'b1;
    m_axi.wready  = 1'b1;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    m_axi.rvalid  = 1'b0;
    m_axi.rdata   = '0;
    m_axi.rresp   = 2'b00;
    m_axi.rlast   = 1'b0;
    forever begin
      @(posedge gpu_clk);
      #1;
      if (reset) begin
        wr_valid = 1'b0;
        m_axi.bvalid = 1'b0;
        m_axi.rvalid = 1'b0;
        m_axi.wready = 1'b1;
        r_go = 0; gapcnt = 0; wcnt = 0;
      end else begin
        if (s_w_hs) begin
          void'(src_w.pop_front());
          gapcnt = w_gap;
        end
        if (src_w.size() > 0 && gapcnt == 0) begin
          wr_valid = 1'b1;
          wr_data  = src_w[0].d;
          wr_strb  = src_w[0].s;
        end else begin
          wr_valid = 1'b0;
          if (gapcnt > 0) gapcnt--;
        end
        if (s_w_hs) wcnt = 0;
        else if (wcnt < 1000) wcnt++;
        m_axi.wready = (wcnt >= w_stall);

        if (s_b_hs) m_axi.bvalid = 1'b0;
        else if (s_wlast_hs) begin
          m_axi.bvalid = 1'b1;
          m_axi.bresp  = bresp_cfg;
        end

        if (s_ar_hs) r_go = 1;
        if (s_r_hs) begin
          void'(r_src.pop_front());
          if (r_src.size() == 0) r_go = 0;
        end
        rcyc++;
        if (!(m_axi.rvalid && !s_r_hs)) begin
          if (r_go && r_src.size() > 0 && !(r_stall && (rcyc % 3 == 0))) begin
            m_axi.rvalid = 1'b1;
            m_axi.rdata  = r_src[0].d;
            m_axi.rresp  = r_src[0].r;
            m_axi.rlast  = r_src[0].l;
          end else begin
            m_axi.rvalid = 1'b0;
          end
        end
        rd_ready = rdr_toggle ? ~rd_ready : 1'b1;
      end
    end
  end

  task automatic prep_write(input int n, input logic [31:0] base, input int stall,
                            input int gap, input logic [1:0] br);
    logic [3:0] full = 4'hF;
    for (int i = 0; i < n; i++) begin
      wbeat_t b;
      b.d = base + 32'(i);
      b.s = full >> (i % 4);
      b.l = (i == n - 1);
      src_w.push_back(b);
      exp_w.push_back(b);
    end
    w_stall = stall;
    w_gap = gap;
    bresp_cfg = br;
    exp_resp = br;
  endtask

  // rr packs one 2-bit response per beat, beat 0 in the low bits.
  task automatic prep_read(input int n, input logic [31:0] base, input logic [31:0] rr,
                           input bit omit_last);
    logic [1:0] acc = 2'b00;
    bit ended = 0;
    for (int i = 0; i < n; i++) begin
      rbeat_t b;
      b.d = base + 32'(i);
      b.r = rr[2*i +: 2];
      b.l = !omit_last && (i == n - 1);
      r_src.push_back(b);
    end
    for (int i = 0; i < n && !ended; i++) begin
      exp_rd.push_back(r_src[i]);
      if (r_src[i].r > acc) acc = r_src[i].r;
      if (r_src[i].l) ended = 1;
    end
    exp_resp = ended ? acc : 2'b10;
  endtask

  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [8:0] len);
    int eff;
    bit ok = 0;
    eff = (len == 0) ? 1 : ((int'(len) > MAXL) ? MAXL : int'(len));
    exp_addr = addr & ~32'd3;
    exp_len = 8'(eff - 1);
    @(posedge gpu_clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    for (int i = 0; i < 20; i++) begin
      @(negedge gpu_clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge gpu_clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [8:0] len);
    int start;
    start = done_cnt;
    issue_cmd(wr, addr, len);
    for (int i = 0; i < 400; i++) begin
      @(posedge gpu_clk);
      if (done_cnt != start) break;
    end
    repeat (3) @(posedge gpu_clk);
    chk("done_once", 64'(done_cnt - start), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_valids", 64'({m_axi.awvalid, m_axi.arvalid, m_axi.wvalid, m_axi.bready,
                           m_axi.rready, wr_ready, rd_valid, done}), 64'(0));
    chk("rst_resp", 64'(resp), 64'(0));
    chk("rst_awaddr", 64'(m_axi.awaddr), 64'(0));
    chk("rst_awlen", 64'(m_axi.awlen), 64'(0));
    #20 reset = 1'b0;
    repeat (2) @(posedge gpu_clk);

    // single-beat write
    prep_write(1, 32'hDEADBEEF, 0, 0, 2'b00);
    run_cmd(1'b1, 32'h0000_1000, 9'd1);
    chk("t1_resp", 64'(resp), 64'(2'b00));
    chk("t1_awlen", 64'(last_axlen), 64'(8'd0));
    chk("t1_awaddr", 64'(last_axaddr), 64'(32'h1000));

    // 16-beat read with R stalls and a toggling consumer
    r_stall = 1'b1;
    rdr_toggle = 1'b1;
    prep_read(16, 32'h0, 32'h0, 1'b0);
    run_cmd(1'b0, 32'h0000_2000, 9'd16);
    r_stall = 1'b0;
    rdr_toggle = 1'b0;
    chk("t2_arlen", 64'(last_axlen), 64'(8'd15));

    // write with wready backpressure and a gapped source
    prep_write(4, 32'hA5A5_0000, 5, 2, 2'b00);
    run_cmd(1'b1, 32'h0000_1100, 9'd4);
    w_stall = 0;
    w_gap = 0;

    // read response merge: 0,2,0,3
    prep_read(4, 32'h100, 32'h0000_00C8, 1'b0);
    run_cmd(1'b0, 32'h0000_2400, 9'd4);
    chk("t4_resp", 64'(resp), 64'(2'd3));

    // write response SLVERR
    prep_write(2, 32'h55, 0, 0, 2'b10);
    run_cmd(1'b1, 32'h0000_1200, 9'd2);
    chk("t5_resp", 64'(resp), 64'(2'd2));

    // read whose final beat lacks rlast
    prep_read(2, 32'h200, 32'h0, 1'b1);
    run_cmd(1'b0, 32'h0000_2800, 9'd2);
    chk("t6_resp", 64'(resp), 64'(2'd2));

    // oversize length clamps to 16 beats
    prep_write(16, 32'h7000, 0, 0, 2'b00);
    run_cmd(1'b1, 32'h0000_1800, 9'd20);
    chk("t7_awlen", 64'(last_axlen), 64'(8'd15));

    // zero length is one beat; low address bits dropped
    prep_read(1, 32'hCAFE_0000, 32'h0, 1'b0);
    run_cmd(1'b0, 32'h0000_3006, 9'd0);
    chk("t8_arlen", 64'(last_axlen), 64'(8'd0));
    chk("t8_araddr", 64'(last_axaddr), 64'(32'h3004));

    // asynchronous reset during beat 2 of an 8-beat write
    prep_write(8, 32'h8000, 0, 0, 2'b00);
    issue_cmd(1'b1, 32'h0000_1400, 9'd8);
    for (int i = 0; i < 100; i++) begin
      @(posedge gpu_clk);
      if (exp_w.size() <= 7) break;
    end
    #3;
    chk("t9_pre_wvalid", 64'({m_axi.wvalid, wr_ready}), 64'(2'b11));
    reset = 1'b1;
    #1;
    chk("t9_rst_outputs", 64'({m_axi.awvalid, m_axi.wvalid, wr_ready, m_axi.bready,
                               m_axi.arvalid, m_axi.rready, rd_valid, done}), 64'(0));
    src_w.delete();
    exp_w.delete();
    r_src.delete();
    exp_rd.delete();
    busy = 1'b0;
    repeat (3) @(posedge gpu_clk);
    #2 reset = 1'b0;
    @(negedge gpu_clk);
    chk("t9_cmd_ready", 64'(cmd_ready), 64'(1));

    // normal read after the reset
    prep_read(1, 32'h1234_5678, 32'h0, 1'b0);
    run_cmd(1'b0, 32'h0000_4000, 9'd1);
    chk("t10_resp", 64'(resp), 64'(2'd0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
